// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout game controller.
package breakout_pkg;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } game_state_e;

    localparam logic [7:0] KEY_LEFT   = 8'h04;
    localparam logic [7:0] KEY_RIGHT  = 8'h07;
    localparam logic [7:0] KEY_LAUNCH = 8'h2C;

    localparam int NUM_BRICKS = 9;
    localparam int BRICK_COLS = 3;
    localparam int BRICK_X0   = 160;
    localparam int BRICK_DX   = 120;
    localparam int BRICK_Y0   = 40;
    localparam int BRICK_DY   = 32;

    localparam logic [9:0] BRICK_H  = 10'd16;
    localparam logic [9:0] PADDLE_H = 10'd8;

    localparam logic [7:0] AUTOSERVE_CNT = 8'd120;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/breakout_game_ctrl_paddle_mover.sv
// Paddle X register: steps left/right on keycode, clamped to the screen.
module paddle_mover
    import breakout_pkg::*;
#(
    parameter int PADDLE_W    = 40,
    parameter int PADDLE_STEP = 4,
    parameter int X_MAX       = 639
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] keycode_i,
    input  logic       en_i,
    output logic [9:0] paddle_x_o
);

    localparam logic [9:0] X_LIM  = 10'(X_MAX + 1 - PADDLE_W);
    localparam logic [9:0] X_HOME = 10'((X_MAX + 1 - PADDLE_W) / 2);
    localparam logic [9:0] STEP   = 10'(PADDLE_STEP);

    logic [9:0] paddle_x_q;
    logic [9:0] paddle_x_d;

    always_comb begin
        paddle_x_d = paddle_x_q;
        if (en_i) begin
            case (keycode_i)
                KEY_LEFT: begin
                    if (paddle_x_q < STEP) paddle_x_d = '0;
                    else paddle_x_d = paddle_x_q - STEP;
                end
                KEY_RIGHT: begin
                    // Compare against LIM-STEP so the sum never overflows.
                    if (paddle_x_q > X_LIM - STEP) paddle_x_d = X_LIM;
                    else paddle_x_d = paddle_x_q + STEP;
                end
                default: paddle_x_d = paddle_x_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) paddle_x_q <= X_HOME;
        else paddle_x_q <= paddle_x_d;
    end

    assign paddle_x_o = paddle_x_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game controller: geometry, paddle, score, lives, serve/play FSM.
// Optional GAME_AUTOSERVE_EN launches the ball after 120 idle SERVE frames.
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int PADDLE_W    = 40,
    parameter int PADDLE_Y    = 440,
    parameter int PADDLE_STEP = 4,
    parameter int X_MAX       = 639,
    parameter int LOSE_Y      = 470,
    parameter int LIVES       = 3
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic [7:0]   keycode,
    input  logic [8:0]   brick_exists,
    input  logic [9:0]   ball_y,
    output logic [99:0]  brick_x_vals,
    output logic [99:0]  brick_y_vals,
    output logic [9:0]   brick_width,
    output logic [9:0]   brick_height,
    output logic [9:0]   paddle_height,
    output logic         start_ball,
    output logic         ball_rst,
    output logic [7:0]   score,
    output logic [1:0]   lives,
    output logic [1:0]   game_state
);

    localparam logic [9:0] LOSE_Y_W = 10'(LOSE_Y);
    localparam logic [1:0] LIVES_W  = 2'(LIVES);

    game_state_e state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  score_q, score_d;
    logic [8:0]  prev_q;
    logic        start_q, start_d;
    logic        brst_q, brst_d;
    logic [9:0]  paddle_x;
    logic        move_en;
    logic        launch;
    logic [8:0]  cleared;
    logic [8:0]  score_sum;

    assign move_en = (state_q == ST_SERVE) || (state_q == ST_PLAY);

    paddle_mover #(
        .PADDLE_W    (PADDLE_W),
        .PADDLE_STEP (PADDLE_STEP),
        .X_MAX       (X_MAX)
    ) u_paddle (
        .clk_i      (frame_clk),
        .rst_i      (Reset),
        .keycode_i  (keycode),
        .en_i       (move_en),
        .paddle_x_o (paddle_x)
    );

`ifdef GAME_AUTOSERVE_EN
    logic [7:0] serve_cnt_q, serve_cnt_d;

    // Counter is held at zero outside SERVE, so it restarts on every entry.
    always_comb begin
        serve_cnt_d = '0;
        if (state_q == ST_SERVE) serve_cnt_d = serve_cnt_q + 8'd1;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) serve_cnt_q <= '0;
        else serve_cnt_q <= serve_cnt_d;
    end

    assign launch = (keycode == KEY_LAUNCH) ||
                    (serve_cnt_q == AUTOSERVE_CNT - 8'd1);
`else
    assign launch = (keycode == KEY_LAUNCH);
`endif

    assign cleared   = prev_q & ~brick_exists;
    assign score_sum = {1'b0, score_q} + {5'd0, popcount9(cleared)};
    assign score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        start_d = 1'b0;
        brst_d  = 1'b0;
        unique case (state_q)
            ST_SERVE: begin
                if (launch) begin
                    state_d = ST_PLAY;
                    start_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // A simultaneous clear-all and miss counts as a win.
                if (brick_exists == '0) begin
                    state_d = ST_WIN;
                end else if (ball_y >= LOSE_Y_W) begin
                    lives_d = lives_q - 2'd1;
                    brst_d  = 1'b1;
                    state_d = (lives_d == 2'd0) ? ST_LOSE : ST_SERVE;
                end
            end
            ST_WIN, ST_LOSE: state_d = state_q;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= ST_SERVE;
            lives_q <= LIVES_W;
            score_q <= '0;
            prev_q  <= '1;
            start_q <= 1'b0;
            brst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            score_q <= score_d;
            prev_q  <= brick_exists;
            start_q <= start_d;
            brst_q  <= brst_d;
        end
    end

    always_comb begin
        brick_x_vals = '0;
        brick_y_vals = '0;
        for (int i = 0; i < NUM_BRICKS; i++) begin
            brick_x_vals[10*i +: 10] =
                10'(BRICK_X0 + BRICK_DX * (i % BRICK_COLS));
            brick_y_vals[10*i +: 10] =
                10'(BRICK_Y0 + BRICK_DY * (i / BRICK_COLS));
        end
        brick_x_vals[99:90] = paddle_x;
        brick_y_vals[99:90] = 10'(PADDLE_Y);
    end

    assign brick_width   = 10'(PADDLE_W);
    assign brick_height  = BRICK_H;
    assign paddle_height = PADDLE_H;
    assign start_ball    = start_q;
    assign ball_rst      = brst_q;
    assign score         = score_q;
    assign lives         = lives_q;
    assign game_state    = state_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Scoreboard bench for breakout_game_ctrl: directed frames, queued expectations.
module tb_breakout_game_ctrl;

    localparam int X = -1;
`ifdef GAME_AUTOSERVE_EN
    localparam int SST = -1;
`else
    localparam int SST = 0;
`endif

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  keycode = '0;
    logic [8:0]  brick_exists = 9'h1FF;
    logic [9:0]  ball_y = '0;
    logic [99:0] brick_x_vals;
    logic [99:0] brick_y_vals;
    logic [9:0]  brick_width;
    logic [9:0]  brick_height;
    logic [9:0]  paddle_height;
    logic        start_ball;
    logic        ball_rst;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [1:0]  game_state;

    breakout_game_ctrl dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .keycode       (keycode),
        .brick_exists  (brick_exists),
        .ball_y        (ball_y),
        .brick_x_vals  (brick_x_vals),
        .brick_y_vals  (brick_y_vals),
        .brick_width   (brick_width),
        .brick_height  (brick_height),
        .paddle_height (paddle_height),
        .start_ball    (start_ball),
        .ball_rst      (ball_rst),
        .score         (score),
        .lives         (lives),
        .game_state    (game_state)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        string tag;
        int px;
        int sc;
        int lv;
        int st;
        int sb;
        int br;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input string f,
                       input int act, input int want);
        if (want < 0) return;
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s.%s got=%0d want=%0d", tag, f, act, want);
        end
    endtask

    // Monitor: every frame edge with a pending expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "paddle_x", int'(brick_x_vals[99:90]), e.px);
                chk(e.tag, "score", int'(score), e.sc);
                chk(e.tag, "lives", int'(lives), e.lv);
                chk(e.tag, "state", int'(game_state), e.st);
                chk(e.tag, "start_ball", int'(start_ball), e.sb);
                chk(e.tag, "ball_rst", int'(ball_rst), e.br);
            end
        end
    end

    task automatic frame(input string tag, input logic [7:0] k,
                         input logic [8:0] ex, input logic [9:0] by,
                         input logic r, input int px, input int sc,
                         input int lv, input int st, input int sb,
                         input int br);
        exp_t e;
        @(negedge frame_clk);
        keycode = k;
        brick_exists = ex;
        ball_y = by;
        Reset = r;
        e.tag = tag;
        e.px = px;
        e.sc = sc;
        e.lv = lv;
        e.st = st;
        e.sb = sb;
        e.br = br;
        q.push_back(e);
    endtask

    initial begin
        int px;
        frame("reset", 8'h00, 9'h1FF, 10'd0, 1'b1, 300, 0, 3, 0, 0, 0);
        frame("reset", 8'h00, 9'h1FF, 10'd0, 1'b1, 300, 0, 3, 0, 0, 0);

        for (int k = 1; k <= 80; k++) begin
            px = 300 - 4 * k;
            if (px < 0) px = 0;
            frame("left", 8'h04, 9'h1FF, 10'd0, 1'b0, px, 0, 3, SST, SST, 0);
        end
        for (int k = 1; k <= 200; k++) begin
            px = 4 * k;
            if (px > 600) px = 600;
            frame("right", 8'h07, 9'h1FF, 10'd0, 1'b0, px, 0, 3, SST, SST, 0);
        end

        frame("rst2", 8'h00, 9'h1FF, 10'd0, 1'b1, 300, 0, 3, 0, 0, 0);
        frame("launch", 8'h2C, 9'h1FF, 10'd0, 1'b0, 300, 0, 3, 1, 1, 0);
        frame("launch2", 8'h2C, 9'h1FF, 10'd0, 1'b0, 300, 0, 3, 1, 0, 0);
        frame("launch3", 8'h2C, 9'h1FF, 10'd0, 1'b0, 300, 0, 3, 1, 0, 0);
        frame("spaceplay", 8'h2C, 9'h1FF, 10'd0, 1'b0, 300, 0, 3, 1, 0, 0);

        frame("clear3", 8'h00, 9'h1F8, 10'd0, 1'b0, 300, 3, 3, 1, 0, 0);
        frame("hold", 8'h00, 9'h1F8, 10'd0, 1'b0, 300, 3, 3, 1, 0, 0);

        frame("miss1", 8'h00, 9'h1F8, 10'd470, 1'b0, 300, 3, 2, 0, 0, 1);
        frame("miss1b", 8'h00, 9'h1F8, 10'd0, 1'b0, 300, 3, 2, 0, 0, 0);
        frame("serve2", 8'h2C, 9'h1F8, 10'd0, 1'b0, 300, 3, 2, 1, 1, 0);
        frame("miss2", 8'h00, 9'h1F8, 10'd470, 1'b0, 300, 3, 1, 0, 0, 1);
        frame("miss2b", 8'h00, 9'h1F8, 10'd0, 1'b0, 300, 3, 1, 0, 0, 0);
        frame("serve3", 8'h2C, 9'h1F8, 10'd0, 1'b0, 300, 3, 1, 1, 1, 0);
        frame("miss3", 8'h00, 9'h1F8, 10'd470, 1'b0, 300, 3, 0, 3, 0, 1);
        for (int k = 0; k < 5; k++) begin
            frame("lose", 8'h04, 9'h1F8, 10'd0, 1'b0, 300, 3, 0, 3, 0, 0);
        end
        frame("losesp", 8'h2C, 9'h1F8, 10'd0, 1'b0, 300, 3, 0, 3, 0, 0);

        frame("rst3", 8'h00, 9'h1FF, 10'd0, 1'b1, 300, 0, 3, 0, 0, 0);
        frame("launch4", 8'h2C, 9'h1FF, 10'd0, 1'b0, 300, 0, 3, 1, 1, 0);
        frame("win", 8'h00, 9'h000, 10'd475, 1'b0, 300, 9, 3, 2, 0, 0);
        for (int k = 0; k < 3; k++) begin
            frame("winhold", 8'h07, 9'h000, 10'd475, 1'b0, 300, 9, 3, 2, 0, 0);
        end

        frame("rst4", 8'h00, 9'h1FF, 10'd0, 1'b1, 300, 0, 3, 0, 0, 0);
        frame("launch5", 8'h2C, 9'h1FF, 10'd0, 1'b0, 300, 0, 3, 1, 1, 0);
        frame("midrst", 8'h2C, 9'h1F0, 10'd480, 1'b1, 300, 0, 3, 0, 0, 0);
        frame("postrst", 8'h00, 9'h1F0, 10'd0, 1'b0, 300, 4, 3, 0, 0, 0);

`ifdef GAME_AUTOSERVE_EN
        frame("rst5", 8'h00, 9'h1FF, 10'd0, 1'b1, 300, 0, 3, 0, 0, 0);
        for (int k = 1; k < 120; k++) begin
            frame("idle", 8'h00, 9'h1FF, 10'd0, 1'b0, 300, 0, 3, 0, 0, 0);
        end
        frame("autoserve", 8'h00, 9'h1FF, 10'd0, 1'b0, 300, 0, 3, 1, 1, 0);
`endif

        repeat (3) @(negedge frame_clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end

        chk("geom", "brick_width", int'(brick_width), 40);
        chk("geom", "brick_height", int'(brick_height), 16);
        chk("geom", "paddle_height", int'(paddle_height), 8);
        chk("geom", "x0", int'(brick_x_vals[9:0]), 160);
        chk("geom", "x4", int'(brick_x_vals[49:40]), 280);
        chk("geom", "y4", int'(brick_y_vals[49:40]), 72);
        chk("geom", "x8", int'(brick_x_vals[89:80]), 400);
        chk("geom", "y8", int'(brick_y_vals[89:80]), 104);
        chk("geom", "paddle_y", int'(brick_y_vals[99:90]), 440);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/breakout_game_ctrl.md
# breakout_game_ctrl

Game-level controller for the USB-keyboard breakout design. It sits upstream of the ball/collision block and drives that block's brick and paddle geometry buses, paddle position, launch strobe and per-serve ball reset. It also consumes the ball block's `brick_exists` and ball Y position to track score, lives and win/lose state. Updates happen once per frame on `frame_clk`.

## Interface
- `PADDLE_W`, 40: paddle and brick width in pixels; driven on `brick_width`.
- `PADDLE_Y`, 440: paddle top edge Y.
- `PADDLE_STEP`, 4: paddle pixels moved per frame.
- `X_MAX`, 639: rightmost screen column.
- `LOSE_Y`, 470: ball Y at or above this value counts as a miss.
- `LIVES`, 3: lives at reset; range 1–3.
- `frame_clk` in 1: the only clock, one edge per video frame.
- `Reset` in 1: synchronous, active-high.
- `keycode` in 8: current USB HID keycode. 0x04 (A) is left, 0x07 (D) is right, 0x2C (space) is launch. Any other value is no action.
- `brick_exists` in 9: live-brick mask from the ball block.
- `ball_y` in 10: ball Y position from the ball block.
- `brick_x_vals` out 100: ten 10-bit X fields. Field i occupies bits [10i+9:10i]. Field 9 is the paddle.
- `brick_y_vals` out 100: ten 10-bit Y fields, same packing as `brick_x_vals`.
- `brick_width` out 10: constant `PADDLE_W`.
- `brick_height` out 10: constant 16.
- `paddle_height` out 10: constant 8.
- `start_ball` out 1: one-cycle launch pulse.
- `ball_rst` out 1: one-cycle pulse; the top level ORs it into the ball block's Reset.
- `score` out 8: bricks cleared, saturating at 255.
- `lives` out 2: remaining lives.
- `game_state` out 2: 0 = SERVE, 1 = PLAY, 2 = WIN, 3 = LOSE.

## Operation
- **Brick layout (constant).** For brick i: col = i%3, row = i/3.
  - x = 160 + 120·col
  - y = 40 + 32·row
- **Paddle fields.** Field 9 carries X = `paddle_x` and Y = `PADDLE_Y`.
- **Paddle movement** (SERVE and PLAY states only):
  - 0x04: `paddle_x` −= `PADDLE_STEP`, clamped at 0.
  - 0x07: `paddle_x` += `PADDLE_STEP`, clamped at `X_MAX`+1−`PADDLE_W` (600).
  - Paddle holds in WIN and LOSE.
- **Score.**
  - `cleared` = `prev_exists` & ~`brick_exists`.
  - `score` += popcount(`cleared`), saturating at 255.
  - `prev_exists` ← `brick_exists` every cycle.
- **FSM transitions:**
  - SERVE → PLAY when `keycode` = 0x2C; `start_ball` is pulsed.
  - PLAY → WIN when `brick_exists` = 0.
  - PLAY, when `ball_y` ≥ `LOSE_Y`:
    - `lives` decrements and `ball_rst` is pulsed.
    - If the new `lives` = 0, go to LOSE; otherwise go to SERVE.
  - WIN and LOSE hold until `Reset`.
- **Space outside SERVE** is ignored.
- **Simultaneous last-brick clear and miss:** WIN has priority. `lives` and `ball_rst` are unaffected.

## Timing
- All outputs are registered. The geometry constants and `brick_width`/`brick_height`/`paddle_height` are combinational constants.
- Keycode-to-`paddle_x` latency is 1 cycle.
- `start_ball` is high for exactly the one cycle after the edge that sampled space in SERVE. `game_state` = PLAY in that same cycle.
- `ball_rst` is high for exactly one cycle, aligned with the `lives` decrement and the state change.
- A miss is detected only in PLAY. After `ball_rst` the ball re-centres, so no double decrement occurs.
- The score update appears 1 cycle after `brick_exists` falls.
- Reset values:
  - `game_state` = SERVE, `paddle_x` = 300, `score` = 0, `lives` = `LIVES`.
  - `start_ball` = 0, `ball_rst` = 0, `prev_exists` = all ones.
- `Reset` mid-game restores all reset values on the next edge, overriding any pending transition.

## Configuration
- `GAME_AUTOSERVE_EN`
  - **Defined:** SERVE contains an 8-bit frame counter, cleared on entry to SERVE. When it reaches 120, the FSM launches as if space were pressed. Space still launches immediately.
  - **Undefined:** no counter; only space launches.

## Structure
- `breakout_pkg` holds:
  - the state enum,
  - the keycode constants 0x04, 0x07 and 0x2C,
  - the brick origin/pitch constants and the height constants,
  - the autoserve count of 120.
- Sub-module `paddle_mover` implements the `paddle_x` register, step and clamp. Its inputs are `keycode` and an enable.

## Test plan
- Reset, then hold 0x04 for 80 frames → `paddle_x` steps 300, 296, … and clamps at 0. Then hold 0x07 for 200 frames → `paddle_x` clamps at 600.
- In SERVE, drive `keycode` 0x2C for 3 frames → exactly one `start_ball` pulse and `game_state` = 1. Repeated space in PLAY → no further pulse.
- In PLAY, drop `brick_exists` from 0x1FF to 0x1F8 in one frame → `score` = 3 one cycle later.
- In PLAY, set `ball_y` = 470 → `lives` 3→2, one `ball_rst` pulse, state SERVE. Repeat twice → `lives` = 0, state LOSE, and the paddle is frozen.
- In PLAY, drive `brick_exists` to 0 and `ball_y` = 475 in the same cycle → WIN, `lives` unchanged, no `ball_rst`.
- With `GAME_AUTOSERVE_EN`, idle in SERVE → `start_ball` asserts 120 frames after entry. Assert `Reset` in PLAY → all reset values appear on the next edge.
